seq_loader: RTL and testbench
=============================

SEQ_LOADER -- requirements
Module: seq_loader

Interface
REQ-001 SHALL have parameter N, default 128, meaning maximum sequence length in symbols.
REQ-002 SHALL have parameter Bit, default $clog2(N), meaning RAM address width.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  pulse to begin loading a new sequence.
REQ-006 SHALL have port in_valid  input  1  in_char holds a valid character.
REQ-007 SHALL have port in_char  input  8  ASCII nucleotide character.
REQ-008 SHALL have port in_last  input  1  the current character is the final one of the sequence.
REQ-009 SHALL have port in_ready  output  1  loader accepts a character this cycle.
REQ-010 SHALL have port we  output  1  sequence-RAM write enable.
REQ-011 SHALL have port addr_din  output  Bit  sequence-RAM write address.
REQ-012 SHALL have port din  output  3  encoded symbol to write.
REQ-013 SHALL have port len  output  Bit+1  number of symbols written.
REQ-014 SHALL have port done  output  1  level, sequence loaded successfully.
REQ-015 SHALL have port err  output  1  level, load aborted.

Function
REQ-016 SHALL implement states IDLE, LOAD, DONE, ERR.
REQ-017 SHALL encode characters G/g->3'b001, C/c->3'b110, A/a->3'b100, T/t->3'b011.
REQ-018 SHALL count a character as accepted only in a cycle where in_valid and in_ready are both 1.
REQ-019 SHALL drive in_ready=1 only in LOAD.
REQ-020 SHALL transition IDLE->LOAD, DONE->LOAD, or ERR->LOAD on start=1, clearing len, done, err and the write pointer to 0 in the same edge.
REQ-021 SHALL ignore start while in LOAD.
REQ-022 SHALL, on acceptance of a valid character, register we=1, addr_din=write pointer, din=code on the next edge (1-cycle latency), then increment the write pointer and len.
REQ-023 SHALL hold we=0 in every cycle without an accepted valid character; addr_din and din hold their last values.
REQ-024 SHALL transition LOAD->DONE on acceptance of a valid character with in_last=1, writing that symbol and setting done=1 on the same edge.
REQ-025 SHALL, on acceptance of a character outside the eight accepted ones, perform no write, go to ERR, and set err=1; len keeps the count of prior symbols.
REQ-026 SHALL, on acceptance of the N-th valid symbol with in_last=0, write it and go to ERR with err=1 (overflow); len=N.
REQ-027 SHALL write the N-th symbol with in_last=1 and go to DONE (exact fill is legal).
REQ-028 SHALL keep done and err mutually exclusive and hold each until the next start or reset.
REQ-029 SHALL never assert we outside the write cycle of an accepted valid symbol, including in DONE and ERR.

Reset
REQ-030 SHALL, when rst=0 at a rising edge, enter IDLE with we=0, addr_din=0, din=0, len=0, done=0, err=0, in_ready=0.
REQ-031 SHALL let reset take priority over start and handshakes; a reset mid-LOAD aborts with no further writes.
REQ-032 SHALL have no asynchronous behaviour on rst.

Verification
REQ-033 Bench: reset, start, stream "CACTG" with in_last on G -> writes at addr 0..4 of 110,100,110,011,001, one cycle after each handshake; done=1; len=5.
REQ-034 Bench: stream "caX" -> writes 110,100 only; err=1; len=2; no write for X.
REQ-035 Bench: N=5, stream "AAAAAA" with no in_last -> 5 writes; err=1 after the 5th; in_ready=0 thereafter; 6th character not accepted.
REQ-036 Bench: in_valid toggling with gaps during "GT" -> exactly 2 writes (001, 011) at addr 0,1; we=0 in gap cycles.
REQ-037 Bench: rst=0 in the middle of a load -> all outputs zero next edge; state IDLE; start then reloads from addr 0.
REQ-038 Bench: start while in DONE -> len=0, done=0, in_ready=1 next cycle; start pulsed during LOAD -> no effect.

Source files
------------

// File: rtl/seq_loader.sv
// Purpose: encode an ASCII nucleotide stream (G/C/A/T, either case) into 3-bit symbols and write them to sequence RAM.
// Latency: a symbol accepted on an edge is presented on we/addr_din/din right after that edge; len/done/err update on the same edge.
// Backpressure: in_ready is high only while loading; once done, err or reset is reached, no further characters are taken.
//
// Ports:
//   clk, rst             single rising-edge clock; synchronous active-low reset
//   start                pulse to begin a new load (ignored while loading)
//   in_valid/in_char/in_last/in_ready   character stream with valid-ready handshake
//   we/addr_din/din      sequence-RAM write port (registered)
//   len                  number of symbols written so far
//   done/err             sticky status levels, cleared by start or reset
module seq_loader #(
    parameter int N   = 128,
    parameter int Bit = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           in_valid,
    input  logic [7:0]     in_char,
    input  logic           in_last,
    output logic           in_ready,
    output logic           we,
    output logic [Bit-1:0] addr_din,
    output logic [2:0]     din,
    output logic [Bit:0]   len,
    output logic           done,
    output logic           err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [Bit:0] LEN_MAX = (Bit+1)'(N);

    state_t         state, state_nxt;
    logic           we_nxt;
    logic [Bit-1:0] addr_nxt;
    logic [2:0]     din_nxt;
    logic [Bit:0]   len_nxt;
    logic           done_nxt;
    logic           err_nxt;

    logic           sym_ok;
    logic [2:0]     sym_code;
    logic           accept;

    always_comb begin
        sym_ok   = 1'b1;
        sym_code = 3'b000;
        case (in_char)
            "G", "g": sym_code = 3'b001;
            "C", "c": sym_code = 3'b110;
            "A", "a": sym_code = 3'b100;
            "T", "t": sym_code = 3'b011;
            default:  sym_ok   = 1'b0;
        endcase
    end

    assign in_ready = (state == LOAD);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_nxt = state;
        we_nxt    = 1'b0;
        addr_nxt  = addr_din;
        din_nxt   = din;
        len_nxt   = len;
        done_nxt  = done;
        err_nxt   = err;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_nxt = LOAD;
                    len_nxt   = '0;
                    done_nxt  = 1'b0;
                    err_nxt   = 1'b0;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (sym_ok) begin
                        // len doubles as the write pointer: it always equals the next free address
                        we_nxt   = 1'b1;
                        addr_nxt = len[Bit-1:0];
                        din_nxt  = sym_code;
                        len_nxt  = len + 1'b1;
                        if (in_last) begin
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
                        end else if (len_nxt == LEN_MAX) begin
                            // RAM full but the stream continues: overflow
                            state_nxt = ERR;
                            err_nxt   = 1'b1;
                        end
                    end else begin
                        state_nxt = ERR;
                        err_nxt   = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            we       <= 1'b0;
            addr_din <= '0;
            din      <= '0;
            len      <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            we       <= we_nxt;
            addr_din <= addr_nxt;
            din      <= din_nxt;
            len      <= len_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
        end
    end

endmodule

// File: tb/tb_seq_loader.sv
// Purpose: directed self-checking bench for seq_loader with a 5-symbol RAM.
// Latency: each check is sampled 1 time unit after the rising edge it follows.
// Backpressure: characters are held until in_ready is seen, bounded by a cycle budget.
module tb_seq_loader;

    localparam int N   = 5;
    localparam int Bit = $clog2(N);

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           in_valid;
    logic [7:0]     in_char;
    logic           in_last;
    logic           in_ready;
    logic           we;
    logic [Bit-1:0] addr_din;
    logic [2:0]     din;
    logic [Bit:0]   len;
    logic           done;
    logic           err;

    int vectors  = 0;
    int miscomps = 0;

    logic [Bit-1:0] wadr[$];
    logic [2:0]     wdin[$];

    seq_loader #(.N(N), .Bit(Bit)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_char  (in_char),
        .in_last  (in_last),
        .in_ready (in_ready),
        .we       (we),
        .addr_din (addr_din),
        .din      (din),
        .len      (len),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // write log: we is stable mid-cycle
    always @(negedge clk) begin
        if (we === 1'b1) begin
            wadr.push_back(addr_din);
            wdin.push_back(din);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscomps++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_log();
        wadr.delete();
        wdin.delete();
    endtask

    // hold the character until the handshake edge, then drop valid
    task automatic send(input logic [7:0] c, input logic last);
        int k;
        k = 0;
        in_valid = 1'b1;
        in_char  = c;
        in_last  = last;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        if (!in_ready) chk("ready_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic chk_write(input string tag, input int a, input logic [2:0] d);
        chk({tag, "_we"},   32'(we),       32'd1);
        chk({tag, "_addr"}, 32'(addr_din), 32'(a));
        chk({tag, "_din"},  32'(din),      32'(d));
    endtask

    logic [7:0] cactg_chr[5];
    logic [2:0] cactg_cod[5];

    initial begin
        cactg_chr = '{"C", "A", "C", "T", "G"};
        cactg_cod = '{3'b110, 3'b100, 3'b110, 3'b011, 3'b001};

        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_char  = 8'h00;
        in_last  = 1'b0;

        // reset state
        tick();
        tick();
        chk("rst_we",    32'(we),       32'd0);
        chk("rst_addr",  32'(addr_din), 32'd0);
        chk("rst_din",   32'(din),      32'd0);
        chk("rst_len",   32'(len),      32'd0);
        chk("rst_done",  32'(done),     32'd0);
        chk("rst_err",   32'(err),      32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        tick();
        chk("idle_ready", 32'(in_ready), 32'd0);

        // "CACTG": exact fill of the 5-entry RAM, ends in DONE
        pulse_start();
        chk("start_ready", 32'(in_ready), 32'd1);
        clear_log();
        for (int i = 0; i < 5; i++) begin
            send(cactg_chr[i], i == 4);
            chk_write("cactg", i, cactg_cod[i]);
        end
        chk("cactg_done",  32'(done),     32'd1);
        chk("cactg_err",   32'(err),      32'd0);
        chk("cactg_len",   32'(len),      32'd5);
        chk("cactg_ready", 32'(in_ready), 32'd0);
        tick();
        chk("cactg_we_done", 32'(we), 32'd0);
        chk("cactg_nwr", 32'(wadr.size()), 32'd5);

        // start from DONE clears status
        pulse_start();
        chk("restart_len",   32'(len),      32'd0);
        chk("restart_done",  32'(done),     32'd0);
        chk("restart_ready", 32'(in_ready), 32'd1);

        // "caX" with a start pulse mid-load
        clear_log();
        send("c", 1'b0);
        chk_write("ca0", 0, 3'b110);
        pulse_start();
        chk("ld_start_len",   32'(len),      32'd1);
        chk("ld_start_ready", 32'(in_ready), 32'd1);
        chk("ld_start_we",    32'(we),       32'd0);
        send("a", 1'b0);
        chk_write("ca1", 1, 3'b100);
        send("X", 1'b0);
        chk("x_we",    32'(we),       32'd0);
        chk("x_err",   32'(err),      32'd1);
        chk("x_done",  32'(done),     32'd0);
        chk("x_len",   32'(len),      32'd2);
        chk("x_ready", 32'(in_ready), 32'd0);
        tick();
        chk("x_nwr", 32'(wadr.size()), 32'd2);

        // overflow: six A's with no in_last
        pulse_start();
        clear_log();
        for (int i = 0; i < 5; i++) begin
            send("A", 1'b0);
            chk_write("ovf", i, 3'b100);
        end
        chk("ovf_err",   32'(err),      32'd1);
        chk("ovf_done",  32'(done),     32'd0);
        chk("ovf_len",   32'(len),      32'd5);
        chk("ovf_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_char  = "A";
        for (int i = 0; i < 3; i++) tick();
        chk("ovf6_ready", 32'(in_ready), 32'd0);
        chk("ovf6_we",    32'(we),       32'd0);
        chk("ovf6_len",   32'(len),      32'd5);
        in_valid = 1'b0;
        chk("ovf_nwr", 32'(wadr.size()), 32'd5);

        // "GT" with valid gaps
        pulse_start();
        clear_log();
        send("G", 1'b0);
        chk_write("gap0", 0, 3'b001);
        tick();
        chk("gap_we1", 32'(we), 32'd0);
        tick();
        chk("gap_we2", 32'(we), 32'd0);
        send("T", 1'b1);
        chk_write("gap1", 1, 3'b011);
        chk("gap_done", 32'(done), 32'd1);
        chk("gap_len",  32'(len),  32'd2);
        tick();
        chk("gap_nwr", 32'(wadr.size()), 32'd2);
        if (wadr.size() == 2) begin
            chk("gap_log_a0", 32'(wadr[0]), 32'd0);
            chk("gap_log_d0", 32'(wdin[0]), 32'(3'b001));
            chk("gap_log_a1", 32'(wadr[1]), 32'd1);
            chk("gap_log_d1", 32'(wdin[1]), 32'(3'b011));
        end

        // reset in the middle of a load, with a character on offer
        pulse_start();
        clear_log();
        send("A", 1'b0);
        send("A", 1'b0);
        in_valid = 1'b1;
        in_char  = "C";
        rst      = 1'b0;
        tick();
        chk("mrst_we",    32'(we),       32'd0);
        chk("mrst_addr",  32'(addr_din), 32'd0);
        chk("mrst_din",   32'(din),      32'd0);
        chk("mrst_len",   32'(len),      32'd0);
        chk("mrst_done",  32'(done),     32'd0);
        chk("mrst_err",   32'(err),      32'd0);
        chk("mrst_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        chk("mrst_idle_ready", 32'(in_ready), 32'd0);
        chk("mrst_nwr", 32'(wadr.size()), 32'd2);
        pulse_start();
        send("G", 1'b1);
        chk_write("reload", 0, 3'b001);
        chk("reload_done", 32'(done), 32'd1);
        chk("reload_len",  32'(len),  32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomps);
        $finish;
    end

endmodule
